gpr_file: RTL and testbench
===========================

Name: gpr_file

Overview:
- Architectural general-purpose register file on the write-back side of the core. It is the receiving end of the write-back GPR write port.
- Accepts one write per cycle and serves two combinational read ports with write-first bypass.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards.
- Provides a software/debug clear sweep. During the sweep the block deasserts o_ready to write-back.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): register width.
- GPRS_WIDTH, `GPRS_WIDTH (5): register index width.
- GPRS_NUM, 1 << GPRS_WIDTH: number of registers. x0 is hardwired to zero.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  write-back stage valid.
- o_ready  out  1  register file accepting writes; drives write-back i_ready.
- i_gpr_wr_en  in  1  write enable.
- i_gpr_wr_id  in  GPRS_WIDTH  write index.
- i_gpr_wr_data  in  DATA_WIDTH  write data.
- i_gpr_rd_id_1  in  GPRS_WIDTH  read port 1 index.
- i_gpr_rd_id_2  in  GPRS_WIDTH  read port 2 index.
- o_gpr_rd_data_1  out  DATA_WIDTH  read port 1 data.
- o_gpr_rd_data_2  out  DATA_WIDTH  read port 2 data.
- o_gpr_rd_busy_1  out  1  read port 1 register has a pending write.
- o_gpr_rd_busy_2  out  1  read port 2 register has a pending write.
- i_sb_set_en  in  1  decode issued an instruction that writes i_sb_set_id.
- i_sb_set_id  in  GPRS_WIDTH  scoreboard index to mark busy.
- i_clr  in  1  start clear sweep (single-cycle pulse).
- o_clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset is asynchronous, active-low, single clock i_clk.
  - On reset: all registers = 0, scoreboard = 0, FSM = RUN.
  - Outputs during reset: o_ready = 1, o_clr_done = 0. Read data of any index = 0 while in reset.
- Write commit: wr_fire = i_valid && o_ready && i_gpr_wr_en && (i_gpr_wr_id != 0). On wr_fire, the register is updated at the rising edge.
- Writes to x0 are dropped. x0 always reads 0 and is never busy.
- Reads are combinational from the register array, with write-first bypass:
  - If wr_fire and rd_id == wr_id (nonzero), rd_data = i_gpr_wr_data in the same cycle.
  - Each port bypasses independently. Both ports reading the write index both see the bypassed value.
- Scoreboard, one bit per register, bit 0 forced to 0:
  - Set when i_sb_set_en at the edge.
  - Cleared when wr_fire for the same index at the edge.
  - Set and clear of the same index in the same cycle: set wins, because the new producer is still outstanding.
- Busy outputs:
  - o_gpr_rd_busy_n = sb[rd_id] && !(wr_fire && wr_id == rd_id). A bypassed write hides busy in the same cycle.
- FSM states are RUN and CLR.
  - RUN: o_ready = 1. If i_clr, go to CLR with index counter = 1.
  - CLR: o_ready = 0, so no writes commit.
    - Each cycle: reg[cnt] = 0 and sb[cnt] = 0, then cnt += 1.
    - When cnt == GPRS_NUM-1, after clearing that register, return to RUN and pulse o_clr_done for that one cycle (the edge entering RUN asserts it for the following cycle).
  - Sweep length is GPRS_NUM-1 cycles (31 for the default).
  - Reads during CLR return the current array contents; cleared entries read 0. Bypass is inactive during CLR.
  - i_sb_set_en is ignored during CLR.
  - i_clr while already in CLR is ignored; the counter is not restarted.
  - Reset asserted mid-sweep aborts immediately: FSM = RUN, all registers = 0.
- Write/clear race: i_clr together with a wr_fire in the RUN cycle commits the write first, then the sweep clears it.
- Counter width is GPRS_WIDTH. The counter does not wrap, because the exit occurs at GPRS_NUM-1.

Decomposition:
- Shared cfg package holds:
  - DATA_WIDTH and GPRS_WIDTH defaults.
  - GPR_ZERO index constant.
  - FSM enum gpr_state_e {GPR_RUN, GPR_CLR}.
- One natural sub-module, gpr_scoreboard: the busy-bit array with set/clear priority and masked lookup for two ports.
- The data array, bypass and FSM stay in gpr_file.

Test Plan:
- Write x5 = 0xDEADBEEF, next cycle read port 1 id 5 → 0xDEADBEEF. Same cycle as the write, port 2 id 5 → 0xDEADBEEF via bypass.
- Write x0 = 0x12345678 → reads of x0 = 0, and no array change is visible on any later read.
- Set sb[7] via i_sb_set_en, read id 7 → busy = 1.
  - Write x7 with wr_fire → busy = 0 that cycle and after.
  - Set and write x7 in the same cycle → busy = 1 next cycle.
- Fill x1..x31 with index values, pulse i_clr:
  - o_ready = 0 for exactly 31 cycles.
  - o_clr_done pulses once.
  - All reads = 0 and all busy = 0 after.
  - A write presented during CLR is not committed.
- Assert i_rst_n = 0 mid-sweep at cnt = 10 → o_ready = 1 immediately and all reads = 0. After release a write x3 = 0xA5A5A5A5 succeeds on the first cycle.
- i_clr together with write x9 = 0x55 in RUN → x9 reads 0 after the sweep completes.

Source files
------------

// File: rtl/gpr_file_pkg.sv
// Shared configuration for the general-purpose register file: width defaults,
// the hardwired-zero index and the sweep FSM encoding.
package gpr_file_pkg;

    localparam int GPR_DATA_WIDTH = 32;
    localparam int GPR_GPRS_WIDTH = 5;
    localparam int GPR_ZERO       = 0;

    typedef enum logic {
        GPR_RUN = 1'b0,
        GPR_CLR = 1'b1
    } gpr_state_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register (x0 never busy),
// decode sets, write-back or the clear sweep clears, set wins a same-cycle race.
module gpr_scoreboard
    import gpr_file_pkg::*;
#(
    parameter int GPRS_WIDTH = GPR_GPRS_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_set_en,
    input  logic [GPRS_WIDTH-1:0] i_set_id,
    input  logic                  i_wr_fire,
    input  logic [GPRS_WIDTH-1:0] i_wr_id,
    input  logic                  i_sweep_en,
    input  logic [GPRS_WIDTH-1:0] i_sweep_id,
    input  logic [GPRS_WIDTH-1:0] i_rd_id_1,
    input  logic [GPRS_WIDTH-1:0] i_rd_id_2,
    output logic                  o_busy_1,
    output logic                  o_busy_2
);

    localparam int GPRS_NUM = 1 << GPRS_WIDTH;

    logic [GPRS_NUM-1:0] sb;
    logic [GPRS_NUM-1:0] sb_next;

    // A newly issued producer stays outstanding even if an older write to the
    // same register retires in the same cycle.
    always_comb begin
        sb_next = sb;
        for (int i = 1; i < GPRS_NUM; i++) begin
            if (i_set_en && i_set_id == GPRS_WIDTH'(i)) begin
                sb_next[i] = 1'b1;
            end else if ((i_wr_fire && i_wr_id == GPRS_WIDTH'(i)) ||
                         (i_sweep_en && i_sweep_id == GPRS_WIDTH'(i))) begin
                sb_next[i] = 1'b0;
            end
        end
        sb_next[GPR_ZERO] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    assign o_busy_1 = sb[i_rd_id_1] && !(i_wr_fire && i_wr_id == i_rd_id_1);
    assign o_busy_2 = sb[i_rd_id_2] && !(i_wr_fire && i_wr_id == i_rd_id_2);

endmodule

// File: rtl/gpr_file.sv
// Architectural GPR file: one write port, two write-first bypassed read ports,
// RAW scoreboard and a clear sweep that stalls write-back while it runs.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int GPRS_WIDTH = GPR_GPRS_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_gpr_wr_en,
    input  logic [GPRS_WIDTH-1:0] i_gpr_wr_id,
    input  logic [DATA_WIDTH-1:0] i_gpr_wr_data,
    input  logic [GPRS_WIDTH-1:0] i_gpr_rd_id_1,
    input  logic [GPRS_WIDTH-1:0] i_gpr_rd_id_2,
    output logic [DATA_WIDTH-1:0] o_gpr_rd_data_1,
    output logic [DATA_WIDTH-1:0] o_gpr_rd_data_2,
    output logic                  o_gpr_rd_busy_1,
    output logic                  o_gpr_rd_busy_2,
    input  logic                  i_sb_set_en,
    input  logic [GPRS_WIDTH-1:0] i_sb_set_id,
    input  logic                  i_clr,
    output logic                  o_clr_done,
    output logic                  o_state
);

    // Write-back handshake: a write commits on a rising edge where
    // i_valid && o_ready; o_ready drops only while the clear sweep runs.
    localparam int GPRS_NUM = 1 << GPRS_WIDTH;
    localparam logic [GPRS_WIDTH-1:0] ZERO_ID  = GPRS_WIDTH'(GPR_ZERO);
    localparam logic [GPRS_WIDTH-1:0] FIRST_ID = GPRS_WIDTH'(1);
    localparam logic [GPRS_WIDTH-1:0] LAST_ID  = GPRS_WIDTH'(GPRS_NUM - 1);

    gpr_state_e            state;
    gpr_state_e            state_next;
    logic [GPRS_WIDTH-1:0] cnt;
    logic                  clr_done_q;
    logic                  sweep_en;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] regs [GPRS_NUM];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= GPR_RUN;
            cnt        <= FIRST_ID;
            clr_done_q <= 1'b0;
        end else begin
            state      <= state_next;
            clr_done_q <= (state == GPR_CLR) && (cnt == LAST_ID);
            // Counter parks at 1 outside the sweep so it never wraps.
            if (state == GPR_CLR && cnt != LAST_ID) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= FIRST_ID;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            GPR_RUN: if (i_clr) state_next = GPR_CLR;
            GPR_CLR: if (cnt == LAST_ID) state_next = GPR_RUN;
            default: state_next = GPR_RUN;
        endcase
    end

    always_comb begin
        o_ready    = (state == GPR_RUN);
        sweep_en   = (state == GPR_CLR);
        o_clr_done = clr_done_q;
        o_state    = state;
    end

    // Gated by reset so the bypass cannot leak write data while in reset.
    assign wr_fire = i_rst_n && i_valid && o_ready && i_gpr_wr_en &&
                     (i_gpr_wr_id != ZERO_ID);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < GPRS_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[i_gpr_wr_id] <= i_gpr_wr_data;
        end else if (sweep_en) begin
            regs[cnt] <= '0;
        end
    end

    always_comb begin
        o_gpr_rd_data_1 = regs[i_gpr_rd_id_1];
        if (i_gpr_rd_id_1 == ZERO_ID) begin
            o_gpr_rd_data_1 = '0;
        end else if (wr_fire && i_gpr_wr_id == i_gpr_rd_id_1) begin
            o_gpr_rd_data_1 = i_gpr_wr_data;
        end
    end

    always_comb begin
        o_gpr_rd_data_2 = regs[i_gpr_rd_id_2];
        if (i_gpr_rd_id_2 == ZERO_ID) begin
            o_gpr_rd_data_2 = '0;
        end else if (wr_fire && i_gpr_wr_id == i_gpr_rd_id_2) begin
            o_gpr_rd_data_2 = i_gpr_wr_data;
        end
    end

    gpr_scoreboard #(
        .GPRS_WIDTH(GPRS_WIDTH)
    ) u_scoreboard (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_set_en  (i_sb_set_en && (state == GPR_RUN)),
        .i_set_id  (i_sb_set_id),
        .i_wr_fire (wr_fire),
        .i_wr_id   (i_gpr_wr_id),
        .i_sweep_en(sweep_en),
        .i_sweep_id(cnt),
        .i_rd_id_1 (i_gpr_rd_id_1),
        .i_rd_id_2 (i_gpr_rd_id_2),
        .o_busy_1  (o_gpr_rd_busy_1),
        .o_busy_2  (o_gpr_rd_busy_2)
    );

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: directed vector table, randomized run against a
// behavioural register/scoreboard model, and hand-written sweep/reset sequences.
module tb_gpr_file;

    localparam int DW  = 32;
    localparam int GW  = 5;
    localparam int NUM = 1 << GW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid, ready, wr_en;
    logic [GW-1:0] wr_id, rd1, rd2, set_id;
    logic [DW-1:0] wr_data, d1, d2;
    logic          b1, b2, set_en, clr, clr_done, dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_regs [NUM];
    logic          m_sb   [NUM];
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          valid;
        logic          wr_en;
        logic [GW-1:0] wr_id;
        logic [DW-1:0] wr_data;
        logic [GW-1:0] rd1;
        logic [GW-1:0] rd2;
        logic          set_en;
        logic [GW-1:0] set_id;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        logic          eb1;
        logic          eb2;
    } vec_t;

    vec_t vecs [12];

    gpr_file dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_gpr_wr_en    (wr_en),
        .i_gpr_wr_id    (wr_id),
        .i_gpr_wr_data  (wr_data),
        .i_gpr_rd_id_1  (rd1),
        .i_gpr_rd_id_2  (rd2),
        .o_gpr_rd_data_1(d1),
        .o_gpr_rd_data_2(d2),
        .o_gpr_rd_busy_1(b1),
        .o_gpr_rd_busy_2(b2),
        .i_sb_set_en    (set_en),
        .i_sb_set_id    (set_id),
        .i_clr          (clr),
        .o_clr_done     (clr_done),
        .o_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        valid   = 1'b0;
        wr_en   = 1'b0;
        wr_id   = '0;
        wr_data = '0;
        rd1     = '0;
        rd2     = '0;
        set_en  = 1'b0;
        set_id  = '0;
        clr     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [GW-1:0] id, input logic [DW-1:0] data);
        valid   = 1'b1;
        wr_en   = 1'b1;
        wr_id   = id;
        wr_data = data;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (RUN mode) ----------------
    function automatic logic m_fire();
        return valid && wr_en && (wr_id != '0);
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [GW-1:0] id);
        if (id == '0) return '0;
        if (m_fire() && wr_id == id) return wr_data;
        return m_regs[id];
    endfunction

    function automatic logic m_busy(input logic [GW-1:0] id);
        if (id == '0) return 1'b0;
        return m_sb[id] && !(m_fire() && wr_id == id);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_regs[i] = '0;
            m_sb[i]   = 1'b0;
        end
    endtask

    task automatic model_commit();
        if (m_fire()) begin
            m_regs[wr_id] = wr_data;
            m_sb[wr_id]   = 1'b0;
        end
        if (set_en && set_id != '0) m_sb[set_id] = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        int low, done;

        vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 5'd7, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 5'd7, 32'h00000077, 5'd7, 5'd7, 1'b0, 5'd0, 32'h00000077, 32'h00000077, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b0, 5'd0, 32'h00000077, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 5'd7, 32'h00001234, 5'd7, 5'd0, 1'b1, 5'd7, 32'h00001234, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b0, 5'd0, 32'h00001234, 32'h0,        1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 5'd7, 32'h00009999, 5'd7, 5'd0, 1'b0, 5'd0, 32'h00001234, 32'h0,        1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 5'd7, 32'h0000AAAA, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0000AAAA, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 1'b0, 5'd0, 32'h0000AAAA, 32'hDEADBEEF, 1'b0, 1'b0};

        // Reset: a write presented during reset must neither commit nor bypass.
        rst_n = 1'b0;
        idle();
        drive_write(5'd5, 32'hFFFFFFFF);
        rd1 = 5'd5;
        rd2 = 5'd5;
        model_reset();
        next_cycle();
        next_cycle();
        chk("rst_ready", DW'(ready), 32'd1);
        chk("rst_clr_done", DW'(clr_done), 32'd0);
        chk("rst_d1", d1, 32'd0);
        chk("rst_d2", d2, 32'd0);
        rst_n = 1'b1;
        idle();

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            idle();
            valid   = vecs[i].valid;
            wr_en   = vecs[i].wr_en;
            wr_id   = vecs[i].wr_id;
            wr_data = vecs[i].wr_data;
            rd1     = vecs[i].rd1;
            rd2     = vecs[i].rd2;
            set_en  = vecs[i].set_en;
            set_id  = vecs[i].set_id;
            @(negedge clk);
            chk($sformatf("vec%0d_d1", i), d1, vecs[i].exp1);
            chk($sformatf("vec%0d_d2", i), d2, vecs[i].exp2);
            chk($sformatf("vec%0d_b1", i), DW'(b1), DW'(vecs[i].eb1));
            chk($sformatf("vec%0d_b2", i), DW'(b2), DW'(vecs[i].eb2));
            model_commit();
            next_cycle();
        end

        // Randomized run against the model.
        for (int i = 0; i < 300; i++) begin
            idle();
            valid   = 1'($urandom_range(0, 3) != 0);
            wr_en   = 1'($urandom_range(0, 3) != 0);
            wr_id   = GW'($urandom_range(0, NUM - 1));
            wr_data = DW'($urandom);
            rd1     = ($urandom_range(0, 2) == 0) ? wr_id : GW'($urandom_range(0, NUM - 1));
            rd2     = ($urandom_range(0, 2) == 0) ? wr_id : GW'($urandom_range(0, NUM - 1));
            set_en  = 1'($urandom_range(0, 1));
            set_id  = ($urandom_range(0, 3) == 0) ? wr_id : GW'($urandom_range(0, NUM - 1));
            exp_q.push_back(m_rd(rd1));
            exp_q.push_back(m_rd(rd2));
            @(negedge clk);
            chk($sformatf("rnd%0d_d1", i), d1, exp_q.pop_front());
            chk($sformatf("rnd%0d_d2", i), d2, exp_q.pop_front());
            chk($sformatf("rnd%0d_b1", i), DW'(b1), DW'(m_busy(rd1)));
            chk($sformatf("rnd%0d_b2", i), DW'(b2), DW'(m_busy(rd2)));
            model_commit();
            next_cycle();
        end

        // Sweep: fill x1..x31 with their index (and mark busy), then clear.
        for (int i = 1; i < NUM; i++) begin
            idle();
            drive_write(GW'(i), DW'(i));
            set_en = 1'b1;
            set_id = GW'(i);
            next_cycle();
        end
        idle();
        rd1 = 5'd10;
        rd2 = 5'd31;
        @(negedge clk);
        chk("fill_b10", DW'(b1), 32'd1);
        chk("fill_d31", d2, 32'd31);
        next_cycle();
        idle();
        clr = 1'b1;
        @(negedge clk);
        chk("clr_start_ready", DW'(ready), 32'd1);
        next_cycle();
        low  = 0;
        done = 0;
        for (int k = 1; k <= 34; k++) begin
            idle();
            if (k == 1) rd1 = 5'd31;
            if (k == 20) begin
                set_en = 1'b1;
                set_id = 5'd2;
            end
            if (k == 30) begin
                drive_write(5'd4, 32'h0000FFFF);
                rd2 = 5'd4;
            end
            @(negedge clk);
            if (!ready) low++;
            if (clr_done) done++;
            chk($sformatf("sweep_k%0d_ready", k), DW'(ready), (k <= 31) ? 32'd0 : 32'd1);
            chk($sformatf("sweep_k%0d_done", k), DW'(clr_done), (k == 32) ? 32'd1 : 32'd0);
            if (k == 1) chk("sweep_uncleared_x31", d1, 32'd31);
            if (k == 30) chk("sweep_no_bypass_x4", d2, 32'd0);
            next_cycle();
        end
        chk("sweep_low_cycles", DW'(low), 32'd31);
        chk("sweep_done_pulses", DW'(done), 32'd1);
        model_reset();
        for (int i = 0; i < NUM; i++) begin
            idle();
            rd1 = GW'(i);
            rd2 = GW'(NUM - 1 - i);
            @(negedge clk);
            chk($sformatf("post_sweep_d1_x%0d", i), d1, 32'd0);
            chk($sformatf("post_sweep_d2_x%0d", NUM - 1 - i), d2, 32'd0);
            chk($sformatf("post_sweep_b1_x%0d", i), DW'(b1), 32'd0);
            chk($sformatf("post_sweep_b2_x%0d", NUM - 1 - i), DW'(b2), 32'd0);
            next_cycle();
        end

        // Reset asserted mid-sweep at cnt = 10.
        idle();
        drive_write(5'd20, 32'd20);
        next_cycle();
        idle();
        drive_write(5'd3, 32'd3);
        next_cycle();
        idle();
        clr = 1'b1;
        next_cycle();
        for (int k = 1; k < 10; k++) begin
            idle();
            next_cycle();
        end
        idle();
        rd1 = 5'd20;
        rd2 = 5'd3;
        #1;
        chk("mid_sweep_ready", DW'(ready), 32'd0);
        chk("mid_sweep_x20", d1, 32'd20);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", DW'(ready), 32'd1);
        chk("abort_d1", d1, 32'd0);
        chk("abort_d2", d2, 32'd0);
        chk("abort_clr_done", DW'(clr_done), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        idle();
        drive_write(5'd3, 32'hA5A5A5A5);
        rd1 = 5'd3;
        @(negedge clk);
        chk("after_rst_ready", DW'(ready), 32'd1);
        chk("after_rst_bypass_x3", d1, 32'hA5A5A5A5);
        next_cycle();
        idle();
        rd1 = 5'd3;
        rd2 = 5'd20;
        @(negedge clk);
        chk("after_rst_x3", d1, 32'hA5A5A5A5);
        chk("after_rst_x20", d2, 32'd0);
        next_cycle();

        // Clear racing a write to x9; a second clear mid-sweep must not restart it.
        idle();
        clr = 1'b1;
        drive_write(5'd9, 32'h00000055);
        rd1 = 5'd9;
        @(negedge clk);
        chk("race_bypass_x9", d1, 32'h00000055);
        next_cycle();
        low  = 0;
        done = 0;
        for (int k = 1; k <= 34; k++) begin
            idle();
            if (k == 5) clr = 1'b1;
            @(negedge clk);
            if (!ready) low++;
            if (clr_done) done++;
            next_cycle();
        end
        chk("race_low_cycles", DW'(low), 32'd31);
        chk("race_done_pulses", DW'(done), 32'd1);
        idle();
        rd1 = 5'd9;
        rd2 = 5'd3;
        @(negedge clk);
        chk("race_x9_cleared", d1, 32'd0);
        chk("race_x3_cleared", d2, 32'd0);
        next_cycle();

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
